// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one line-wide SRAM port among NUM_REQ GPU engines
// (0 = display, 1 = fill, 2 = texture). Round-robin grant, fixed-length access
// window, one-cycle ack with registered read data. A per-requester lock keeps
// the grant across back-to-back accesses so a read-modify-write of a line
// cannot be interleaved with another engine's traffic.
//
// Optional build macro: SRAM_ARB_PRIORITY_EN -- requester 0 (display) wins any
// IDLE arbitration in which it is requesting. Without it, pure round-robin.
//
// Ports:
//   clk, n_rst                     clock, async active-low reset
//   req/lock/req_read_enable/req_write_enable [NUM_REQ]  per-requester controls
//   req_address    [NUM_REQ*A]     packed, requester k at [k*A +: A]
//   req_write_data [NUM_REQ*DW]    packed, requester k at [k*DW +: DW]
//   grant [NUM_REQ]                one-hot registered grant
//   ack   [NUM_REQ]                one-cycle completion pulse
//   read_data [DW]                 captured SRAM data, valid with ack
//   busy                           arbiter not idle
//   sram_*                         SRAM port
module sram_arbiter #(
  parameter int ADDR_SIZE_BITS  = 24,
  parameter int WORD_SIZE_BYTES = 3,
  parameter int DATA_SIZE_WORDS = 64,
  parameter int NUM_REQ         = 3,
  parameter int ACCESS_CYCLES   = 2,
  localparam int DW = WORD_SIZE_BYTES * DATA_SIZE_WORDS * 8
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ-1:0]          req_read_enable,
  input  logic [NUM_REQ-1:0]          req_write_enable,
  input  logic [NUM_REQ*ADDR_SIZE_BITS-1:0] req_address,
  input  logic [NUM_REQ*DW-1:0]       req_write_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DW-1:0]               read_data,
  output logic                        busy,
  output logic                        sram_read_enable,
  output logic                        sram_write_enable,
  output logic [ADDR_SIZE_BITS-1:0]   sram_address,
  output logic [DW-1:0]               sram_write_data,
  input  logic [DW-1:0]               sram_read_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_LOCKED} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;   // binary index of the granted requester
  logic [IW-1:0]        last_q, last_d;   // last requester that completed
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        rdata_q, rdata_d;

  // Round-robin search starting just above the last winner, wrapping.
  logic                 win_vld;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        cand;
  logic [NUM_REQ-1:0]   win_oh;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(last_q) + 1 + i) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
`ifdef SRAM_ARB_PRIORITY_EN
    // Display scan-out cannot tolerate starvation-by-rotation.
    if (req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`endif
    win_oh = '0;
    for (int k = 0; k < NUM_REQ; k++)
      win_oh[k] = (win_idx == IW'(k));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (win_vld) begin
          grant_d = win_oh;
          gidx_d  = win_idx;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Requests are not re-examined here: a dropped req still completes.
        if (cnt_q == CW'(ACCESS_CYCLES - 1)) begin
          rdata_d = sram_read_data;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        last_d = gidx_q;
        if (lock[gidx_q]) begin
          state_d = S_LOCKED;
        end else begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (req[gidx_q]) begin
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else if (!lock[gidx_q]) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them
  // asynchronously along with the state.
  logic in_access;
  logic has_grant;

  always_comb begin
    in_access         = (state_q == S_ACCESS);
    has_grant         = |grant_q;
    grant             = grant_q;
    ack               = (state_q == S_ACK) ? grant_q : '0;
    read_data         = rdata_q;
    busy              = (state_q != S_IDLE);
    // Write wins when both enables are set; neither set is a no-op access.
    sram_write_enable = in_access & req_write_enable[gidx_q];
    sram_read_enable  = in_access & req_read_enable[gidx_q] & ~req_write_enable[gidx_q];
    sram_address      = has_grant ? req_address[gidx_q*ADDR_SIZE_BITS +: ADDR_SIZE_BITS] : '0;
    sram_write_data   = has_grant ? req_write_data[gidx_q*DW +: DW] : '0;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int A  = 24;
  localparam int DW = 1536;
  localparam int N  = 3;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [N-1:0]      req, lock, re, we;
  logic [N*A-1:0]    addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      grant, ack;
  logic [DW-1:0]     read_data;
  logic              busy, sram_re, sram_we;
  logic [A-1:0]      sram_address;
  logic [DW-1:0]     sram_wdata, sram_rdata;

  sram_arbiter dut (
    .clk(clk), .n_rst(n_rst), .req(req), .lock(lock),
    .req_read_enable(re), .req_write_enable(we),
    .req_address(addr), .req_write_data(wdata),
    .grant(grant), .ack(ack), .read_data(read_data), .busy(busy),
    .sram_read_enable(sram_re), .sram_write_enable(sram_we),
    .sram_address(sram_address), .sram_write_data(sram_wdata),
    .sram_read_data(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // SRAM model: data is a fixed function of the address presented.
  function automatic logic [DW-1:0] pat(input logic [A-1:0] a);
    return {64{a ^ 24'hA5C3E1}};
  endfunction
  assign sram_rdata = pat(sram_address);

  typedef struct packed {
    logic [N-1:0]  oh;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int c, prev, t0, pw, po;
  logic [DW-1:0] d1, d2;
  logic [N-1:0] rr_seq [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got ..%h expected ..%h (low 48 bits)", nm, act[47:0], exp[47:0]);
    end
  endtask

  task automatic set_rq(input int k, input logic r, input logic w,
                        input logic [A-1:0] a, input logic [DW-1:0] d);
    re[k] = r;
    we[k] = w;
    addr[k*A +: A] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic push(input int k, input logic [A-1:0] a);
    exp_t e;
    e.oh = '0;
    e.oh[k] = 1'b1;
    e.data = pat(a);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        seen = 1'b1;
        cyc = cyc_cnt;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL ack_timeout: got no ack expected ack within 30 cycles");
    end
  endtask

  // Scoreboard monitor: pops one expectation per observed ack.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (n_rst && ack != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got %0h expected none", ack);
        end else begin
          exp_t e = exp_q.pop_front();
          chk("ack_who", 64'(ack), 64'(e.oh));
          chkd("ack_data", read_data, e.data);
        end
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; req = '0; lock = '0; re = '0; we = '0; addr = '0; wdata = '0;
    d1 = {64{24'h123456}};
    d2 = {64{24'h0F0F0F}};
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
    fork
      monitor();
    join_none

    // Reset state
    #3;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_en", 64'({sram_re, sram_we}), 64'd0);
    chk("rst_addr", 64'(sram_address), 64'd0);
    chkd("rst_wdata", sram_wdata, '0);
    chkd("rst_rdata", read_data, '0);
    step(); step();
    n_rst = 1'b1;
    step();

    // Round-robin with all three requesting, no lock
    set_rq(0, 1'b1, 1'b0, 24'h000040, '0);
    set_rq(1, 1'b1, 1'b0, 24'h000100, '0);
    set_rq(2, 1'b1, 1'b0, 24'h000200, '0);
    push(0, 24'h000040); push(1, 24'h000100); push(2, 24'h000200); push(0, 24'h000040);
    req = 3'b111;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(c);
      chk("rr_grant", 64'(grant), 64'(rr_seq[i]));
      if (i > 0) chk("rr_spacing", 64'(c - prev), 64'd4);
      prev = c;
    end
    step();
    req = '0;
    step();

    // Single read by requester 1
    set_rq(1, 1'b1, 1'b0, 24'h000100, '0);
    push(1, 24'h000100);
    req = 3'b010;
    t0 = cyc_cnt;
    @(posedge clk); @(negedge clk);
    chk("sr_grant1", 64'(grant), 64'h2);
    chk("sr_en1", 64'({sram_re, sram_we}), 64'h2);
    chk("sr_addr", 64'(sram_address), 64'h000100);
    @(negedge clk);
    chk("sr_grant2", 64'(grant), 64'h2);
    chk("sr_en2", 64'({sram_re, sram_we}), 64'h2);
    wait_ack(c);
    chk("sr_latency", 64'(c - t0), 64'd3);
    step();
    req = '0;
    step();

    // Locked read-modify-write by requester 1 while display also requests
    set_rq(1, 1'b1, 1'b0, 24'h000300, '0);
    lock = 3'b010;
    req = 3'b010;
    push(1, 24'h000300);
    @(posedge clk); @(negedge clk);
    chk("lk_grant_rd", 64'(grant), 64'h2);
    set_rq(0, 1'b1, 1'b0, 24'h000040, '0);
    req[0] = 1'b1;
    wait_ack(c);
    step();
    set_rq(1, 1'b0, 1'b1, 24'h010000, d1);
    push(1, 24'h010000);
    @(negedge clk);
    chk("lk_hold_grant", 64'(grant), 64'h2);
    chk("lk_hold_en", 64'({sram_re, sram_we}), 64'd0);
    chk("lk_hold_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lk_wr_grant", 64'(grant), 64'h2);
    chk("lk_wr_en", 64'({sram_re, sram_we}), 64'h1);
    chk("lk_wr_addr", 64'(sram_address), 64'h010000);
    chkd("lk_wr_data", sram_wdata, d1);
    wait_ack(c);
    step();
    req[1] = 1'b0;
    lock[1] = 1'b0;
    push(0, 24'h000040);
    @(negedge clk);
    chk("lk_still_locked", 64'(grant), 64'h2);
    @(negedge clk);
    chk("lk_released", 64'(grant), 64'h0);
    @(negedge clk);
    chk("lk_next_owner", 64'(grant), 64'h1);
    wait_ack(c);
    step();
    req = '0;
    step();

    // Write precedence: both enables set
    set_rq(2, 1'b1, 1'b1, 24'h000500, d2);
    push(2, 24'h000500);
    req = 3'b100;
    @(posedge clk); @(negedge clk);
    chk("wp_en", 64'({sram_re, sram_we}), 64'h1);
    chkd("wp_data", sram_wdata, d2);
    wait_ack(c);
    step();
    req = '0;
    step();

    // No-op access: neither enable set
    set_rq(2, 1'b0, 1'b0, 24'h000600, '0);
    push(2, 24'h000600);
    req = 3'b100;
    t0 = cyc_cnt;
    @(posedge clk); @(negedge clk);
    chk("noop_grant", 64'(grant), 64'h4);
    chk("noop_en1", 64'({sram_re, sram_we}), 64'd0);
    @(negedge clk);
    chk("noop_en2", 64'({sram_re, sram_we}), 64'd0);
    wait_ack(c);
    chk("noop_latency", 64'(c - t0), 64'd3);
    step();
    req = '0;
    step();

    // Arbitration after requester 0 was last winner, req = 101
    set_rq(0, 1'b1, 1'b0, 24'h000040, '0);
    set_rq(2, 1'b1, 1'b0, 24'h000200, '0);
    push(0, 24'h000040);
    req = 3'b001;
    wait_ack(c);
    step();
    req = 3'b101;
`ifdef SRAM_ARB_PRIORITY_EN
    pw = 0; po = 2;
`else
    pw = 2; po = 0;
`endif
    push(pw, (pw == 0) ? 24'h000040 : 24'h000200);
    push(po, (po == 0) ? 24'h000040 : 24'h000200);
    @(posedge clk); @(negedge clk);
    chk("pr_grant", 64'(grant), 64'(1) << pw);
    wait_ack(c);
    step();
    req[pw] = 1'b0;
    wait_ack(c);
    chk("pr_second", 64'(grant), 64'(1) << po);
    step();
    req = '0;
    step();

    // Reset asserted during the first enable cycle
    set_rq(1, 1'b1, 1'b0, 24'h000700, '0);
    req = 3'b010;
    @(posedge clk); @(negedge clk);
    chk("mr_pre_grant", 64'(grant), 64'h2);
    n_rst = 1'b0;
    #1;
    chk("mr_grant", 64'(grant), 64'd0);
    chk("mr_ack", 64'(ack), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_en", 64'({sram_re, sram_we}), 64'd0);
    chk("mr_addr", 64'(sram_address), 64'd0);
    chkd("mr_rdata", read_data, '0);
    req = '0;
    step();
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mr_after_grant", 64'(grant), 64'd0);
      chk("mr_after_busy", 64'(busy), 64'd0);
    end

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single SRAM port among up to NUM_REQ engines of the 2D GPU: fill engine, texture loader and display scan-out. Each requester presents one line-wide access (64 pixels × 24 bits) with a level request. The arbiter grants one requester at a time, round-robin, and holds the SRAM enables for a fixed access window. It returns a one-cycle acknowledge with registered read data. A lock input keeps the grant across back-to-back accesses, so the fill engine's read-modify-write of a line is never interleaved.

## Interface
- ADDR_SIZE_BITS, 24, SRAM address width
- WORD_SIZE_BYTES, 3, bytes per pixel word
- DATA_SIZE_WORDS, 64, words per access; data width DW = WORD_SIZE_BYTES*DATA_SIZE_WORDS*8 (1536)
- NUM_REQ, 3, number of requesters; index 0 = display, 1 = fill, 2 = texture
- ACCESS_CYCLES, 2, cycles SRAM enables are held per access (≥1)

- clk  in  1  clock; all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester access request (level)
- lock  in  NUM_REQ  keep grant after current access
- req_read_enable  in  NUM_REQ  read access
- req_write_enable  in  NUM_REQ  write access
- req_address  in  NUM_REQ*ADDR_SIZE_BITS  packed addresses, requester k at [k*A +: A]
- req_write_data  in  NUM_REQ*DW  packed write data, requester k at [k*DW +: DW]
- grant  out  NUM_REQ  one-hot registered grant
- ack  out  NUM_REQ  one-cycle access-complete pulse to granted requester
- read_data  out  DW  registered read data, valid while ack is high
- busy  out  1  high in any state other than IDLE
- sram_read_enable  out  1  to SRAM
- sram_write_enable  out  1  to SRAM
- sram_address  out  ADDR_SIZE_BITS  to SRAM
- sram_write_data  out  DW  to SRAM
- sram_read_data  in  DW  from SRAM

## Operation
- States: IDLE, ACCESS, ACK, LOCKED.
- IDLE: if any req bit is high, select a winner, register grant, clear cycle counter, go to ACCESS. The winner is the first set bit searching upward (wrapping) from last_winner+1. Otherwise stay in IDLE with grant = 0.
- ACCESS: SRAM outputs are muxed from the granted requester's address, data and enables.
  - Write precedence: write_enable high forces sram_write_enable = 1 and sram_read_enable = 0.
  - If neither enable is set, the access is a no-op: both SRAM enables stay low, but it still completes and acks.
  - The counter increments each cycle. On the cycle the counter equals ACCESS_CYCLES-1, sram_read_data is captured into read_data and the state moves to ACK.
- ACK: ack[g] = 1, SRAM enables low, last_winner ← g. If lock[g] is high go to LOCKED, else go to IDLE and clear grant.
- LOCKED: grant held, SRAM enables low. If req[g] is high go to ACCESS (same grant, counter cleared). Else if lock[g] is low go to IDLE and clear grant. Other requesters wait.
- Requester rules:
  - Hold address, data and enables stable from req assertion until ack.
  - Deassert req on the edge after ack unless another access is wanted.
  - The arbiter ignores req changes during ACCESS and ACK.
- With no grant, sram_address and sram_write_data are driven 0.

## Timing
- Reset values: grant 0, ack 0, read_data 0, busy 0, sram_read_enable 0, sram_write_enable 0, sram_address 0, sram_write_data 0, state IDLE, last_winner NUM_REQ-1, so the first search starts at requester 0.
- Latency: req sampled high at edge T gives grant and SRAM enables from T+1 through T+ACCESS_CYCLES. ack is high in cycle T+ACCESS_CYCLES+1.
- Minimum spacing between unlocked accesses is ACCESS_CYCLES+2 cycles. A locked follow-on adds 1 cycle (LOCKED→ACCESS).
- Simultaneous requests are resolved only in IDLE, in a single cycle.
- A requester dropping req during ACCESS does not abort the access; it still receives ack.
- Reset asserted mid-access: all outputs drop to reset values immediately (asynchronously); no ack is issued.
- read_data holds its last captured value outside ACK.

## Configuration
- SRAM_ARB_PRIORITY_EN defined: requester 0 (display) wins any IDLE arbitration in which req[0] is high, regardless of the round-robin pointer. LOCKED is still honoured, so display waits for a locked owner to release.
- Not defined: pure round-robin across all requesters.

## Test plan
- Single read: reset, then req=3'b010, read, address 24'h000100, SRAM returns pattern A → grant=3'b010 for 2 cycles with sram_read_enable=1 and sram_address=24'h000100; ack[1] pulses one cycle later with read_data=A.
- Round-robin: req=3'b111 held with no lock → grant sequence 001, 010, 100, 001; each ack is separated by 4 cycles.
- Locked RMW: requester 1 with lock=1 does a read, then a write to 24'h010000, while req[0]=1 throughout → no grant to 0 until lock[1] falls; the write shows sram_write_enable=1 with requester 1 data.
- Write precedence / no-op: both enables high → only sram_write_enable asserted. Neither enable set → no SRAM enables, ack still arrives at T+3.
- Reset mid-ACCESS: n_rst low during the first enable cycle → all outputs 0 immediately; after release, IDLE with grant=0 and no stale ack.
- With SRAM_ARB_PRIORITY_EN: last winner 0, req=3'b101 → grant 001 again. Without the macro → grant 100.
